// File: rtl/fpu_sqrt_pkg.sv
// Shared types and constants for the binary32 square-root controller:
// FSM states, operand classes and the special-case screening function.
package fpu_sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        ROUND,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_PINF,
        CLS_QNAN,
        CLS_INVALID
    } cls_t;

    localparam logic [31:0] QNAN   = 32'h7FC00000;
    localparam logic [31:0] PINF   = 32'h7F800000;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned ROOT_W = 25;
    localparam int unsigned RAD_W  = 50;

    // First match wins: NaNs, then negative nonzero (incl. -inf and negative
    // subnormals), then zero/subnormal flush, then +inf.
    function automatic cls_t classify(input logic [31:0] a);
        logic [7:0]  e;
        logic [22:0] m;
        cls_t        cls;
        e = a[30:23];
        m = a[22:0];
        if (e == 8'hFF && m != '0)
            cls = m[22] ? CLS_QNAN : CLS_INVALID;
        else if (a[31] && (e != '0 || m != '0))
            cls = CLS_INVALID;
        else if (e == '0)
            cls = CLS_ZERO;
        else if (e == 8'hFF)
            cls = CLS_PINF;
        else
            cls = CLS_NORMAL;
        return cls;
    endfunction

endpackage

// File: rtl/fpu_sqrt_iter_step.sv
// One restoring square-root step: brings down two radicand bits, tries
// subtracting (4*root + 1) and appends the resulting root bit.
module sqrt_iter_step #(
    parameter int unsigned ROOT_W = 25
) (
    input  logic [ROOT_W+1:0] rem,
    input  logic [ROOT_W-1:0] root,
    input  logic [1:0]        bits,
    output logic [ROOT_W+1:0] rem_next,
    output logic [ROOT_W-1:0] root_next
);
    localparam int unsigned REM_W = ROOT_W + 2;

    logic [REM_W+1:0] shifted;
    logic [REM_W+1:0] trial;
    logic [REM_W+1:0] diff;
    logic             ge;
    logic             unused_bits;

    assign shifted   = {rem, bits};
    assign trial     = {2'b00, root, 2'b01};
    assign diff      = shifted - trial;
    assign ge        = (shifted >= trial);
    assign rem_next  = ge ? diff[REM_W-1:0] : shifted[REM_W-1:0];
    // The root MSB is still zero on every step that shifts it out.
    assign root_next = {root[ROOT_W-2:0], ge};

    assign unused_bits = ^{diff[REM_W+1:REM_W], shifted[REM_W+1:REM_W], root[ROOT_W-1]};

endmodule

// File: rtl/fpu_sqrt_ctrl.sv
// Binary32 square-root sequencer: handshake in, special-case screen, serial
// restoring root, RNE round, hold result. FPU_SQRT_FLAGS_EN adds out_flags.
module fpu_sqrt_ctrl #(
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned ROOT_W         = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
`ifdef FPU_SQRT_FLAGS_EN
    ,
    output logic [1:0]  out_flags
`endif
);
    import fpu_sqrt_pkg::*;

    localparam int unsigned REM_W       = ROOT_W + 2;
    localparam int unsigned ITER_CYCLES = ROOT_W / BITS_PER_CYCLE;
    localparam logic [4:0]  LAST_CNT    = 5'(ITER_CYCLES - 1);

    state_t              state;
    logic [RAD_W-1:0]    rad_q;
    logic [REM_W-1:0]    rem_q;
    logic [ROOT_W-1:0]   root_q;
    logic [8:0]          er_q;
    logic [4:0]          cnt;

    logic [BITS_PER_CYCLE:0][REM_W-1:0]  rem_chain;
    logic [BITS_PER_CYCLE:0][ROOT_W-1:0] root_chain;

    assign rem_chain[0]  = rem_q;
    assign root_chain[0] = root_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        sqrt_iter_step #(.ROOT_W(ROOT_W)) u_step (
            .rem       (rem_chain[i]),
            .root      (root_chain[i]),
            .bits      (rad_q[RAD_W-1-2*i -: 2]),
            .rem_next  (rem_chain[i+1]),
            .root_next (root_chain[i+1])
        );
    end

    cls_t              cls_in;
    logic [7:0]        a_exp;
    logic [23:0]       a_man;
    logic [ROOT_W-1:0] x_rad;
    logic [8:0]        er_in;

    assign cls_in = classify(in_a);
    assign a_exp  = in_a[30:23];
    assign a_man  = {1'b1, in_a[22:0]};
    // Odd exponents keep the mantissa as is; even ones double it so the
    // halved exponent stays integral.
    assign x_rad  = a_exp[0] ? {1'b0, a_man} : {a_man, 1'b0};
    assign er_in  = ({1'b0, a_exp} + 9'(BIAS - 1) + {8'b0, a_exp[0]}) >> 1;

    logic        guard;
    logic        sticky;
    logic        inc;
    logic [24:0] mant_sum;
    logic [8:0]  er_rnd;
    logic        unused_rnd;

    assign guard      = root_q[0];
    assign sticky     = |rem_q;
    assign inc        = guard & (sticky | root_q[1]);
    assign mant_sum   = {1'b0, root_q[ROOT_W-1:1]} + {24'b0, inc};
    assign er_rnd     = er_q + {8'b0, mant_sum[24]};
    assign unused_rnd = ^{mant_sum[23], er_rnd[8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            busy       <= 1'b0;
            rad_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            er_q       <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        case (cls_in)
                            CLS_NORMAL: begin
                                state  <= ITER;
                                rad_q  <= {x_rad, {ROOT_W{1'b0}}};
                                rem_q  <= '0;
                                root_q <= '0;
                                er_q   <= er_in;
                                cnt    <= '0;
                            end
                            CLS_ZERO: begin
                                state      <= DONE;
                                out_valid  <= 1'b1;
                                out_result <= {in_a[31], 31'b0};
                            end
                            CLS_PINF: begin
                                state      <= DONE;
                                out_valid  <= 1'b1;
                                out_result <= PINF;
                            end
                            default: begin
                                state      <= DONE;
                                out_valid  <= 1'b1;
                                out_result <= QNAN;
                            end
                        endcase
                    end
                end
                ITER: begin
                    rad_q  <= rad_q << (2 * BITS_PER_CYCLE);
                    rem_q  <= rem_chain[BITS_PER_CYCLE];
                    root_q <= root_chain[BITS_PER_CYCLE];
                    cnt    <= cnt + 5'd1;
                    if (cnt == LAST_CNT)
                        state <= ROUND;
                end
                ROUND: begin
                    out_result <= {1'b0, er_rnd[7:0], mant_sum[22:0]};
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FPU_SQRT_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst)
            out_flags <= '0;
        else if (state == IDLE && in_valid)
            out_flags <= {cls_in == CLS_INVALID, 1'b0};
        else if (state == ROUND)
            out_flags <= {1'b0, guard | sticky};
    end
`endif

endmodule

// File: tb/tb_fpu_sqrt_ctrl.sv
// Directed bench for fpu_sqrt_ctrl: reset, normal roots, specials,
// backpressure, mid-operation reset and back-to-back operands.
module tb_fpu_sqrt_ctrl;

    localparam int unsigned BPC       = 1;
    localparam int          NORM_LAT  = 25 / BPC + 2;
    localparam int          LAT_LIMIT = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        busy;
`ifdef FPU_SQRT_FLAGS_EN
    logic [1:0]  out_flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fpu_sqrt_ctrl #(.BITS_PER_CYCLE(BPC)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
`ifdef FPU_SQRT_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns the negedge count from accept to out_valid.
    task automatic start_op(input logic [31:0] a, output int lat);
        in_a     = a;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < LAT_LIMIT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] exp,
                          input int exp_lat, input logic [1:0] exp_flags);
        int lat;
        start_op(a, lat);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, out_result, exp);
`ifdef FPU_SQRT_FLAGS_EN
        check({tag, " flags"}, {30'b0, out_flags}, {30'b0, exp_flags});
`else
        if (exp_flags > 2'd3) $display("unreachable");
`endif
        @(negedge clk);
        check({tag, " in_ready after"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset out_result", out_result, 32'h0);
        check("reset busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;

        run_op("sqrt4", 32'h40800000, 32'h40000000, NORM_LAT, 2'b00);
        run_op("sqrt2", 32'h40000000, 32'h3FB504F3, NORM_LAT, 2'b01);
        run_op("neg_one", 32'hBF800000, 32'h7FC00000, 1, 2'b10);
        run_op("neg_zero", 32'h80000000, 32'h80000000, 1, 2'b00);
        run_op("pos_inf", 32'h7F800000, 32'h7F800000, 1, 2'b00);
        run_op("subnormal", 32'h00000001, 32'h00000000, 1, 2'b00);
        run_op("qnan", 32'h7FC00001, 32'h7FC00000, 1, 2'b00);
        run_op("snan", 32'h7F800001, 32'h7FC00000, 1, 2'b10);
        run_op("neg_inf", 32'hFF800000, 32'h7FC00000, 1, 2'b10);

        // Backpressure: result held while out_ready low; a stray operand is ignored.
        out_ready = 1'b0;
        start_op(32'h3F800000, lat);
        check("bp latency", lat, NORM_LAT);
        check("bp result", out_result, 32'h3F800000);
        in_a     = 32'h40800000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp out_valid held", {31'b0, out_valid}, 32'd1);
            check("bp result held", out_result, 32'h3F800000);
            check("bp in_ready low", {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp out_valid drop", {31'b0, out_valid}, 32'd0);
        check("bp in_ready rise", {31'b0, in_ready}, 32'd1);
        check("bp busy drop", {31'b0, busy}, 32'd0);

        // Reset in cycle 10 of a normal operand, then resubmit.
        in_a     = 32'h41100000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort out_valid", {31'b0, out_valid}, 32'd0);
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort in_ready", {31'b0, in_ready}, 32'd1);
        run_op("sqrt9", 32'h41100000, 32'h40400000, NORM_LAT, 2'b00);

        run_op("sqrt16", 32'h41800000, 32'h40800000, NORM_LAT, 2'b00);
        run_op("sqrt_quarter", 32'h3E800000, 32'h3F000000, NORM_LAT, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
